// File: rtl/ts_latency_meter.sv
// ts_latency_meter: measures ns between start/end strobes (or a timeout) and
// queues {timeout, delta} results in a small FIFO for a ready/valid consumer.
`default_nettype none

module ts_latency_meter #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] TIMEOUT_NS = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] counter_ns,
  input  logic        evt_start,
  input  logic        evt_end,
  output logic        ts_valid,
  input  logic        ts_ready,
  output logic [30:0] ts_delta,
  output logic        ts_timeout,
  output logic        busy,
  output logic [4:0]  fill_level,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t          state_q;
  logic [30:0]     start_ts_q;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [4:0]      fill_q;
  logic [4:0]      fill_d;
  logic            ovf_q;
  logic            ovf_d;

  logic [30:0]     age;
  logic            timed_out;
  logic            push;
  logic            push_timeout;
  logic            pop;
  logic            accept;
  logic            unused_ok;

  // Counter never sets bit 31, so the age is taken modulo 2^31.
  assign unused_ok    = counter_ns[31];
  assign age          = counter_ns[30:0] - start_ts_q;
  assign timed_out    = (age >= TIMEOUT_NS[30:0]);
  assign push         = (state_q == ARMED) && (evt_end || timed_out);
  assign push_timeout = !evt_end;
  assign pop          = ts_valid && ts_ready;
  assign accept       = push && ((fill_q < 5'(DEPTH)) || pop);

  always_comb begin
    fill_d = fill_q + {4'd0, accept} - {4'd0, pop};
    ovf_d  = ovf_q;
    if (push && !accept) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_ts_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt_start) begin
            start_ts_q <= counter_ns[30:0];
            state_q    <= ARMED;
          end
        end
        ARMED: begin
          // A start strobe always re-arms, even when the same cycle closes a result.
          if (evt_start) begin
            start_ts_q <= counter_ns[30:0];
          end else if (evt_end || timed_out) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {push_timeout, age};
    end
  end

  // Data is forced to zero when empty so stale entries never appear.
  assign ts_valid   = (fill_q != 5'd0);
  assign ts_delta   = ts_valid ? mem_q[rd_ptr_q][30:0] : 31'd0;
  assign ts_timeout = ts_valid ? mem_q[rd_ptr_q][31]   : 1'b0;
  assign busy       = (state_q == ARMED);
  assign fill_level = fill_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ts_latency_meter.sv
// Scoreboard bench for ts_latency_meter: directed scenarios plus random strobes,
// checked against a transaction-level model of the measurement rules.
`default_nettype none

module tb_ts_latency_meter;

  localparam int          DEPTH = 4;
  localparam logic [31:0] TO    = 32'd400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] counter_ns = 32'd0;
  logic        evt_start = 1'b0;
  logic        evt_end = 1'b0;
  logic        ts_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        ts_valid;
  logic [30:0] ts_delta;
  logic        ts_timeout;
  logic        busy;
  logic [4:0]  fill_level;
  logic        overflow;

  ts_latency_meter #(.DEPTH(DEPTH), .TIMEOUT_NS(TO)) dut (
    .clk(clk), .rst(rst), .counter_ns(counter_ns),
    .evt_start(evt_start), .evt_end(evt_end),
    .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_delta(ts_delta), .ts_timeout(ts_timeout),
    .busy(busy), .fill_level(fill_level),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state: what the DUT should hold after the most recent clock edge.
  bit          m_armed = 0;
  logic [31:0] m_start = 0;
  int          m_fill = 0;
  bit          m_ovf = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] c);
    return (c == 32'h7FFF_FFFC) ? 32'd0 : c + 32'd4;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_start = 0; m_fill = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // Apply the rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    logic [31:0] age;
    bit p, to, popm, acc;
    age  = (counter_ns - m_start) & 32'h7FFF_FFFF;
    popm = (m_fill != 0) && ts_ready;
    p = 0; to = 0;
    if (m_armed) begin
      if (evt_end) p = 1;
      else if (age >= TO) begin p = 1; to = 1; end
      if (evt_start) m_start = counter_ns & 32'h7FFF_FFFF;
      else if (p) m_armed = 0;
    end else if (evt_start) begin
      m_armed = 1;
      m_start = counter_ns & 32'h7FFF_FFFF;
    end
    acc = p && ((m_fill < DEPTH) || popm);
    if (acc) exp_q.push_back({to, age[30:0]});
    if (p && !acc) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_fill = m_fill + int'(acc) - int'(popm);
  endtask

  task automatic drive(input bit jmp, input logic [31:0] v,
                       input bit s, input bit e, input bit r, input bit c);
    @(posedge clk); #1;
    if (rst) model_reset(); else model_edge();
    rst        = 1'b0;
    counter_ns = jmp ? v : nxt(counter_ns);
    evt_start  = s; evt_end = e; ts_ready = r; ovf_clr = c;
  endtask

  task automatic tick(input bit s, input bit e, input bit r, input bit c);
    drive(0, 32'd0, s, e, r, c);
  endtask

  task automatic run_to(input logic [31:0] target, input bit r);
    int n = 0;
    while (nxt(counter_ns) != target && n < 2000) begin
      tick(0, 0, r, 0);
      n++;
    end
    if (n >= 2000) chk("run_to_bound", 32'(n), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    if (rst) model_reset(); else model_edge();
    rst = 1'b1; evt_start = 0; evt_end = 0; ovf_clr = 0;
    model_reset();
    repeat (cycles) begin @(posedge clk); #1; model_reset(); end
  endtask

  task automatic check_head(input string name, input logic [30:0] d, input bit t, input bit b);
    chk({name, "_valid"}, 32'(ts_valid), 32'd1);
    chk({name, "_delta"}, 32'(ts_delta), 32'(d));
    chk({name, "_timeout"}, 32'(ts_timeout), 32'(t));
    chk({name, "_busy"}, 32'(busy), 32'(b));
  endtask

  // Monitor: compares status every cycle and each popped result with the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    chk("fill_level", 32'(fill_level), 32'(m_fill));
    chk("ts_valid", 32'(ts_valid), 32'(m_fill != 0));
    chk("busy", 32'(busy), 32'(m_armed));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (rst) begin
      chk("rst_delta", 32'(ts_delta), 32'd0);
      chk("rst_timeout", 32'(ts_timeout), 32'd0);
    end else if (ts_valid && ts_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(ts_delta), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_delta", 32'(ts_delta), 32'(e[30:0]));
        chk("pop_timeout", 32'(ts_timeout), 32'(e[31]));
      end
    end
  end

  initial begin
    do_reset(2);
    tick(0, 0, 1, 0);

    // Plain measurement.
    drive(1, 32'h100, 1, 0, 1, 0);
    run_to(32'h1F4, 1);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_head("basic", 31'hF4, 0, 0);

    // Counter wrap.
    drive(1, 32'h7FFF_FFF0, 1, 0, 1, 0);
    run_to(32'h10, 1);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_head("wrap", 31'h20, 0, 0);

    // Timeout, then a lone end strobe must not push.
    drive(1, 32'd0, 1, 0, 1, 0);
    run_to(32'd400, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    check_head("timeout", 31'd400, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("lone_end_valid", 32'(ts_valid), 32'd0);

    // Overflow with a stalled consumer, then ordered drain and clear.
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0, 0);
      repeat (k) tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
    end
    tick(0, 0, 0, 0);
    chk("ovf_fill", 32'(fill_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(ts_delta), 32'd4);
    repeat (5) tick(0, 0, 1, 0);
    chk("drained_fill", 32'(fill_level), 32'd0);
    chk("ovf_held", 32'(overflow), 32'd1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Simultaneous start+end while armed.
    drive(1, 32'h40, 1, 0, 1, 0);
    run_to(32'h80, 1);
    tick(1, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_head("restart", 31'h40, 0, 1);
    run_to(32'hA0, 1);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_head("after_restart", 31'h20, 0, 0);

    // Reset while armed with queued results.
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    chk("pre_rst_fill", 32'(fill_level), 32'd2);
    do_reset(2);
    chk("rst_valid", 32'(ts_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick(1, 0, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_head("first_after_rst", 31'd4, 0, 0);

    // Random traffic.
    begin
      bit rmode = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) rmode = ~rmode;
        tick($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
             rmode ? ($urandom_range(0, 1) == 1) : 1'b0,
             $urandom_range(0, 19) == 0);
      end
    end

    tick(0, 1, 1, 0);
    repeat (8) tick(0, 0, 1, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ts_latency_meter.md
TS_LATENCY_METER -- requirements
Module: ts_latency_meter

Interface
REQ-001 Parameter DEPTH, default 4: number of result FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT_NS, default 32'd1000000: maximum open-measurement age in ns; a multiple of 4, nonzero, below 2^31.
REQ-003 clk  in  1  single system clock; all logic is in this domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 counter_ns  in  32  free-running timestamp; steps +4 per clk; wraps from 0x7FFF_FFFC to 0; bit 31 always 0.
REQ-006 evt_start  in  1  one-cycle strobe that opens a measurement.
REQ-007 evt_end  in  1  one-cycle strobe that closes a measurement.
REQ-008 ts_valid  out  1  FIFO head holds a result.
REQ-009 ts_ready  in  1  consumer accepts the head; a pop occurs when ts_valid && ts_ready.
REQ-010 ts_delta  out  31  head result: elapsed ns.
REQ-011 ts_timeout  out  1  head result: the measurement was closed by timeout.
REQ-012 busy  out  1  high while state is ARMED.
REQ-013 fill_level  out  5  FIFO occupancy, 0..DEPTH.
REQ-014 overflow  out  1  sticky flag: a result was dropped.
REQ-015 ovf_clr  in  1  clears overflow; a same-cycle drop takes priority and keeps overflow at 1.

Function
REQ-016 States are IDLE and ARMED, with a 31-bit start register start_ts.
REQ-017 Elapsed time age = (counter_ns - start_ts) mod 2^31, computed combinationally each cycle.
REQ-018 IDLE with evt_start: start_ts <= counter_ns[30:0] and state goes to ARMED.
REQ-019 IDLE with evt_end alone: the strobe is ignored; no push and no state change.
REQ-020 ARMED with evt_end: push {age, timeout=0} and go to IDLE.
REQ-021 ARMED with evt_start alone: re-latch start_ts, stay ARMED, no push.
REQ-022 ARMED with evt_start and evt_end in the same cycle: push {age from the old start_ts, 0}, re-latch start_ts, stay ARMED.
REQ-023 ARMED with no evt_end and age >= TIMEOUT_NS: push {age, timeout=1} and go to IDLE.
  - A same-cycle evt_start re-arms instead, with start_ts <= counter_ns.
REQ-024 evt_end takes priority over timeout in the same cycle: push {age, 0}.
REQ-025 Pushes are accepted when fill_level < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the result is dropped and overflow <= 1.
  - State transitions happen regardless of a drop.
REQ-026 The FIFO is first-in first-out.
  - ts_valid = (fill_level != 0).
  - ts_delta and ts_timeout are stable while ts_valid && !ts_ready.
REQ-027 Latency: a push in cycle N into an empty FIFO gives ts_valid = 1 in cycle N+1 with that data; there is no combinational path from evt_* to outputs.
REQ-028 A push and a pop in the same cycle leave fill_level unchanged.
REQ-029 Read and write pointers wrap modulo DEPTH.

Reset
REQ-030 While rst is high:
  - state = IDLE, start_ts = 0, FIFO empty, fill_level = 0.
  - ts_valid = 0, ts_delta = 0, ts_timeout = 0, busy = 0, overflow = 0.
REQ-031 Reset asserted mid-measurement or with the FIFO non-empty discards all contents; no push occurs for the open measurement.
REQ-032 The first evt_start after rst deasserts is honoured in the first clock edge with rst low.

Verification
REQ-033 evt_start at counter_ns=0x100, evt_end at 0x1F4 -> next cycle ts_valid=1, ts_delta=0xF4, ts_timeout=0, busy=0.
REQ-034 Wrap: evt_start at 0x7FFF_FFF0, evt_end at 0x10 -> ts_delta=0x20, ts_timeout=0.
REQ-035 TIMEOUT_NS=400: evt_start at 0, no evt_end -> when counter_ns=400, result {400, 1} is pushed and busy=0 next cycle; a later lone evt_end produces no push.
REQ-036 DEPTH=4, ts_ready=0, five complete measurements -> fill_level=4, overflow=1; raising ts_ready pops the first four in order; ovf_clr then clears overflow.
REQ-037 ARMED since 0x40, evt_start and evt_end together at 0x80 -> pushes ts_delta=0x40 and stays ARMED; evt_end at 0xA0 -> pushes ts_delta=0x20.
REQ-038 rst pulsed while ARMED with 2 queued results -> all outputs at reset values, fill_level=0, no stale result afterwards.
